// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// traps on illegal opcodes or memory timeout. Define MULTICYCLE_CTRL_PERF_EN for perf counters.
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [6:0]           opcode,
  input  logic                 mem_ready,
  input  logic                 branch_taken,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_sel,
  output logic [2:0]           imm_sel,
  output logic                 alu_src_imm,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 illegal,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_TRAP      = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int         WW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [6:0]    op_q;
  logic [WW-1:0] wait_q;
  logic [2:0]    retire_state;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
      OP_OPIMM, OP_OP, OP_LUI, OP_AUIPC: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_fmt(input logic [6:0] op);
    case (op)
      OP_STORE:         imm_fmt = 3'd1;
      OP_BRANCH:        imm_fmt = 3'd2;
      OP_LUI, OP_AUIPC: imm_fmt = 3'd3;
      OP_JAL:           imm_fmt = 3'd4;
      default:          imm_fmt = 3'd0;
    endcase
  endfunction

  // Retirement never aborts on run dropping; run only picks where we go next.
  assign retire_state = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)                state_d = S_DECODE;
        else if (wait_q == WAIT_LAST) state_d = S_TRAP;
      end
      S_DECODE:  state_d = is_legal(opcode) ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        case (op_q)
          OP_LOAD, OP_STORE: state_d = S_MEMORY;
          OP_BRANCH:         state_d = retire_state;
          default:           state_d = S_WRITEBACK;
        endcase
      end
      S_MEMORY: begin
        if (mem_ready)                state_d = (op_q == OP_STORE) ? retire_state : S_WRITEBACK;
        else if (wait_q == WAIT_LAST) state_d = S_TRAP;
      end
      S_WRITEBACK: state_d = retire_state;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_IDLE;
    endcase
  end

  // Wait counter clears on every state change, so each FETCH/MEMORY visit starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (state_d != state_q)
        wait_q <= '0;
      else if (state_q == S_FETCH || state_q == S_MEMORY)
        wait_q <= wait_q + WW'(1);
      else
        wait_q <= '0;
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_sel      = 2'd0;
    imm_sel     = 3'd0;
    alu_src_imm = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 2'd0;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      // op_q is not yet loaded in DECODE, so the format comes from the live opcode.
      S_DECODE: imm_sel = imm_fmt(opcode);
      S_EXECUTE: begin
        imm_sel     = imm_fmt(op_q);
        alu_src_imm = (op_q != OP_OP) && (op_q != OP_BRANCH);
        if (op_q == OP_BRANCH) begin
          pc_write = 1'b1;
          pc_sel   = branch_taken ? 2'd1 : 2'd0;
        end
      end
      S_MEMORY: begin
        imm_sel  = imm_fmt(op_q);
        mem_req  = 1'b1;
        mem_we   = (op_q == OP_STORE);
        pc_write = (op_q == OP_STORE) && mem_ready;
      end
      S_WRITEBACK: begin
        imm_sel   = imm_fmt(op_q);
        reg_write = 1'b1;
        pc_write  = 1'b1;
        if (op_q == OP_LOAD)                           wb_sel = 2'd1;
        else if (op_q == OP_JAL || op_q == OP_JALR)    wb_sel = 2'd2;
        if (op_q == OP_JAL)       pc_sel = 2'd1;
        else if (op_q == OP_JALR) pc_sel = 2'd2;
      end
      S_TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_WIDTH-1:0] cycle_q, instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_TRAP) cycle_q <= cycle_q + CNT_WIDTH'(1);
      if (pc_write)                               instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected cycle traces
// are built from the instruction class and compared every cycle against the DUT.
module tb_multicycle_ctrl;

  localparam int CW = 4;
  localparam int TO = 16;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  logic          clk = 1'b0;
  logic          rst_n, run, mem_ready, branch_taken;
  logic [6:0]    opcode;
  logic          mem_req, mem_we, ir_write, pc_write, alu_src_imm, reg_write, illegal;
  logic [1:0]    pc_sel, wb_sel;
  logic [2:0]    imm_sel, state;
  logic [CW-1:0] cycle_cnt, instret_cnt;
  logic [24:0]   obs;

  multicycle_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
    .pc_write(pc_write), .pc_sel(pc_sel), .imm_sel(imm_sel), .alu_src_imm(alu_src_imm),
    .reg_write(reg_write), .wb_sel(wb_sel), .illegal(illegal), .state(state),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {state, mem_req, mem_we, ir_write, pc_write, pc_sel, imm_sel,
                alu_src_imm, reg_write, wb_sel, illegal, cycle_cnt, instret_cnt};

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [16:0]   exp_q[$];
  logic          rdy_q[$];
  logic [CW-1:0] m_cyc, m_ret;
  string         cur_tag = "idle";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] mk(input int st, input int mreq, input int mwe, input int irw,
                                     input int pcw, input int pcs, input int imm, input int alu,
                                     input int rw, input int wb, input int ill);
    return {3'(st), 1'(mreq), 1'(mwe), 1'(irw), 1'(pcw), 2'(pcs), 3'(imm),
            1'(alu), 1'(rw), 2'(wb), 1'(ill)};
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op inside {LOAD, STORE, BRANCH, JAL, JALR, OPIMM, OP, LUI, AUIPC};
  endfunction

  function automatic int fmt(input logic [6:0] op);
    if (op == STORE)                return 1;
    if (op == BRANCH)               return 2;
    if (op == LUI || op == AUIPC)   return 3;
    if (op == JAL)                  return 4;
    return 0;
  endfunction

  task automatic push(input logic [16:0] rec, input logic rdy);
    exp_q.push_back(rec);
    rdy_q.push_back(rdy);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected per-cycle trace of one instruction, derived from its class and memory delays.
  task automatic plan_instr(input logic [6:0] op, input int fd, input int md, input logic tk,
                            output bit trapped);
    int  f;
    bit  is_br, is_ld, is_st, is_j;
    f       = fmt(op);
    is_br   = (op == BRANCH);
    is_ld   = (op == LOAD);
    is_st   = (op == STORE);
    is_j    = (op == JAL) || (op == JALR);
    trapped = 0;
    for (int i = 0; i < fd && i < TO; i++) push(mk(1,1,0,0,0,0,0,0,0,0,0), 1'b0);
    if (fd >= TO) begin
      push(mk(6,0,0,0,0,0,0,0,0,0,1), rnd_bit());
      trapped = 1;
      return;
    end
    push(mk(1,1,0,1,0,0,0,0,0,0,0), 1'b1);
    push(mk(2,0,0,0,0,0,f,0,0,0,0), rnd_bit());
    if (!legal(op)) begin
      push(mk(6,0,0,0,0,0,0,0,0,0,1), rnd_bit());
      trapped = 1;
      return;
    end
    push(mk(3,0,0,0,is_br, (is_br && tk) ? 1 : 0, f, (op != OP && !is_br) ? 1 : 0, 0,0,0),
         rnd_bit());
    if (is_ld || is_st) begin
      for (int i = 0; i < md && i < TO; i++) push(mk(4,1,is_st,0,0,0,f,0,0,0,0), 1'b0);
      if (md >= TO) begin
        push(mk(6,0,0,0,0,0,0,0,0,0,1), rnd_bit());
        trapped = 1;
        return;
      end
      push(mk(4,1,is_st,0,is_st,0,f,0,0,0,0), 1'b1);
    end
    if (!is_br && !is_st)
      push(mk(5,0,0,0,1, (op == JAL) ? 1 : (op == JALR) ? 2 : 0, f, 0, 1,
              is_ld ? 1 : is_j ? 2 : 0, 0), rnd_bit());
  endtask

  // Apply one planned cycle per clock; sample mid-cycle, then advance the counter model.
  task automatic drain(input int n);
    logic [16:0] rec;
    logic [7:0]  exp_cnt;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      rec       = exp_q.pop_front();
      mem_ready = rdy_q.pop_front();
`ifdef MULTICYCLE_CTRL_PERF_EN
      exp_cnt = {m_cyc, m_ret};
`else
      exp_cnt = 8'h00;
`endif
      @(negedge clk);
      check(cur_tag, 32'(obs), 32'({rec, exp_cnt}));
      if (rec[16:14] != 3'd0 && rec[16:14] != 3'd6) m_cyc = m_cyc + 1'b1;
      if (rec[10]) m_ret = m_ret + 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_steps(input int n);
    cur_tag = "idle";
    for (int i = 0; i < n; i++) push(mk(0,0,0,0,0,0,0,0,0,0,0), rnd_bit());
    drain(n);
  endtask

  task automatic start_run();
    run = 1'b0;
    idle_steps(1);
    run = 1'b1;
    idle_steps(1);
  endtask

  task automatic exec(input logic [6:0] op, input int fd, input int md, input logic tk,
                      input bit drop);
    bit tr;
    plan_instr(op, fd, md, tk, tr);
    opcode       = op;
    branch_taken = tk;
    cur_tag      = $sformatf("op%b_f%0d_m%0d_t%0d", op, fd, md, tk);
    if (drop) begin
      drain(1);
      run = 1'b0;
    end
    drain(100);
    if (drop && !tr) start_run();
  endtask

  task automatic trap_hold(input int n);
    cur_tag = "trap_hold";
    for (int i = 0; i < n; i++) push(mk(6,0,0,0,0,0,0,0,0,0,1), rnd_bit());
    run = rnd_bit();
    drain(n);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'(obs), 32'd0);
    exp_q.delete();
    rdy_q.delete();
    m_cyc = '0;
    m_ret = '0;
    run   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 check("reset_hold", 32'(obs), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops[9];
    int         k;
    bit         tr;
    ops = '{LOAD, STORE, BRANCH, JAL, JALR, OPIMM, OP, LUI, AUIPC};
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; opcode = '0;
    m_cyc = '0; m_ret = '0;
    @(posedge clk);
    @(posedge clk);
    #1 check("por", 32'(obs), 32'd0);
    rst_n = 1'b1;

    idle_steps(2);
    start_run();

    exec(OPIMM, 0, 0, 1'b0, 0);
    exec(STORE, 0, 3, 1'b0, 0);
    exec(BRANCH, 0, 0, 1'b1, 0);
    exec(BRANCH, 0, 0, 1'b0, 0);
    exec(LOAD, 1, 2, 1'b0, 0);
    exec(JAL, 0, 0, 1'b1, 0);
    exec(JALR, 2, 0, 1'b0, 0);
    exec(LUI, 0, 0, 1'b0, 0);
    exec(AUIPC, 0, 0, 1'b1, 0);
    exec(OP, 15, 0, 1'b0, 0);
    exec(LOAD, 0, 15, 1'b0, 0);
    exec(OP, 0, 0, 1'b0, 1);

    for (int i = 0; i < 17; i++) exec(BRANCH, 0, 0, rnd_bit(), 0);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 8);
      exec(ops[k], $urandom_range(0, 3), $urandom_range(0, 3), rnd_bit(),
           ($urandom_range(0, 7) == 0));
    end

    exec(7'b1111111, 0, 0, 1'b0, 0);
    trap_hold(6);
    do_reset();
    start_run();

    exec(OPIMM, TO, 0, 1'b0, 0);
    trap_hold(4);
    do_reset();
    start_run();

    exec(STORE, 0, TO, 1'b0, 0);
    trap_hold(3);
    do_reset();
    start_run();

    plan_instr(LOAD, 0, 3, 1'b0, tr);
    opcode  = LOAD;
    cur_tag = "load_mid_reset";
    drain(5);
    do_reset();
    start_run();
    exec(OPIMM, 0, 0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
